// File: rtl/inst_rom_resp.sv
// Instruction store with programmable fetch wait states; latency WAIT_CYCLES+1 edges from first ce=1 edge.
// Backpressure: stall_req holds the PC generator while a wait is in progress; ce=0 abandons a fetch.
module inst_rom_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           pc,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  addr_err,
  output logic                  stall_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam logic [3:0] WAIT = 4'(WAIT_CYCLES);

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] index;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  bad;

  assign index        = pc[ADDR_WIDTH+1:2];
  assign out_of_range = |pc[31:ADDR_WIDTH+2];
  assign misaligned   = |pc[1:0];
  assign bad          = out_of_range | misaligned;
  assign stall_req    = ce & (cnt != WAIT);

  // Not reset: the store keeps its contents across rst so it can be loaded beforehand.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (!ce) begin
      cnt        <= '0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (cnt != WAIT) begin
      cnt        <= cnt + 4'd1;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      // Same-edge load-port write is not seen here: the read returns the old word.
      cnt        <= '0;
      inst_valid <= 1'b1;
      addr_err   <= bad;
      inst       <= bad ? 32'h0000_0000 : mem[index];
    end
  end

endmodule
